mantissa_divider: RTL and testbench

MANTISSA_DIVIDER -- requirements
Module: mantissa_divider

---
 rtl/mantissa_divider_pkg.sv | 16 +
 rtl/mantissa_divider_if.sv | 33 +++
 rtl/mantissa_div_step.sv | 23 ++
 rtl/mantissa_divider.sv | 121 ++++++++++++
 tb/tb_mantissa_divider.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mantissa_divider_pkg.sv
// Shared types and widths for the mantissa divider.
// Ports: none (package only).
package fpu_div_pkg;

  localparam int MAN_W = 24;
  localparam int QUO_W = 26;
  localparam int REM_W = 25;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/mantissa_divider_if.sv
// Operand/result handshake bundle for the mantissa divider.
// Ports: in_valid/in_ready + man_x/man_y in; out_valid/out_ready + result flags out.
interface mantissa_divider_if
  import fpu_div_pkg::*;
#(
  parameter int W = MAN_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] man_x;
  logic [W-1:0] man_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         redundant_div;
  logic         guard;
  logic         sticky;
  logic         div_by_zero;

  modport master (
    output in_valid, man_x, man_y, out_ready,
    input  in_ready, out_valid, result,
    input  redundant_div, guard, sticky, div_by_zero
  );

  modport slave (
    input  in_valid, man_x, man_y, out_ready,
    output in_ready, out_valid, result,
    output redundant_div, guard, sticky, div_by_zero
  );

endinterface

// File: rtl/mantissa_div_step.sv
// One radix-2 restoring division step (combinational).
// Ports: rem/div in; rem_n (shifted next remainder) and q (quotient bit) out.
module mantissa_div_step
  import fpu_div_pkg::*;
#(
  parameter int W = MAN_W
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] div,
  output logic [W:0]   rem_n,
  output logic         q
);

  logic [W+1:0] diff;
  logic [W:0]   keep;

  assign diff  = {1'b0, rem} - {2'b00, div};
  assign q     = ~diff[W+1];
  assign keep  = q ? diff[W:0] : rem;
  // kept remainder is < div, so the shift never drops a set bit
  assign rem_n = keep << 1;

endmodule

// File: rtl/mantissa_divider.sv
// Iterative 24-bit mantissa divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), bus (slave side of mantissa_divider_if).
module mantissa_divider
  import fpu_div_pkg::*;
#(
  parameter int BIT_LENGTH = MAN_W
) (
  input logic             clk,
  input logic             rst,
  mantissa_divider_if.slave bus
);

  localparam int QW = BIT_LENGTH + 2;

  state_t state, state_n;

  logic [BIT_LENGTH-1:0] div;
  logic [BIT_LENGTH:0]   rem, rem_n;
  logic [QW-1:0]         quo, quo_n;
  logic [CNT_W-1:0]      cnt;
  logic                  qbit, last, y_zero;

  logic                  ready_q, valid_q;
  logic [BIT_LENGTH-1:0] res_q;
  logic                  red_q, grd_q, stk_q, dz_q;

  mantissa_div_step #(.W(BIT_LENGTH)) u_step (
    .rem   (rem),
    .div   (div),
    .rem_n (rem_n),
    .q     (qbit)
  );

  assign quo_n  = (quo << 1) | QW'(qbit);
  assign last   = (cnt == CNT_W'(QW - 1));
  assign y_zero = (bus.man_y == '0);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_n = y_zero ? DONE : CALC;
      CALC: if (last) state_n = DONE;
      DONE: if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n == IDLE);
      valid_q <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      res_q <= '0;
      red_q <= 1'b0;
      grd_q <= 1'b0;
      stk_q <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            div <= bus.man_y;
            rem <= {1'b0, bus.man_x};
            quo <= '0;
            cnt <= '0;
            if (y_zero) begin
              res_q <= '1;
              red_q <= 1'b0;
              grd_q <= 1'b0;
              stk_q <= 1'b0;
              dz_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + CNT_W'(1);
          // normalize straight from the final step's outputs
          if (last) begin
            dz_q <= 1'b0;
            if (quo_n[QW-1]) begin
              res_q <= quo_n[QW-1:2];
              grd_q <= quo_n[1];
              stk_q <= quo_n[0] | (|rem_n);
              red_q <= 1'b0;
            end else begin
              res_q <= quo_n[QW-2:1];
              grd_q <= quo_n[0];
              stk_q <= |rem_n;
              red_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready      = ready_q;
  assign bus.out_valid     = valid_q;
  assign bus.result        = res_q;
  assign bus.redundant_div = red_q;
  assign bus.guard         = grd_q;
  assign bus.sticky        = stk_q;
  assign bus.div_by_zero   = dz_q;

endmodule

// File: tb/tb_mantissa_divider.sv
// Self-checking bench for mantissa_divider with a behavioural quotient model.
// Ports: none (top-level testbench).
module tb_mantissa_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mantissa_divider_if #(.W(24)) bus ();

  mantissa_divider #(.BIT_LENGTH(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [23:0] res;
    logic        g;
    logic        s;
    logic        r;
    logic        z;
    int          lat;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Quotient from plain integer arithmetic. lat counts clock edges from
  // the accepting edge to the edge after which out_valid is seen; the
  // divide-by-zero result is presented in the cycle right after accept.
  function automatic exp_t model(logic [23:0] x, logic [23:0] y);
    exp_t e;
    logic [63:0] n, qq, rr;
    e = '{default: 0};
    if (y == 24'd0) begin
      e.res = 24'hFFFFFF;
      e.z   = 1'b1;
      e.lat = 0;
      return e;
    end
    n  = {40'd0, x} << 25;
    qq = n / {40'd0, y};
    rr = n % {40'd0, y};
    e.lat = 26;
    if (qq[25]) begin
      e.res = qq[25:2];
      e.g   = qq[1];
      e.s   = qq[0] | (rr != 0);
    end else begin
      e.res = qq[24:1];
      e.g   = qq[0];
      e.s   = (rr != 0);
      e.r   = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] pack(exp_t e);
    return {4'd0, e.res, e.g, e.s, e.r, e.z};
  endfunction

  // accept / retire tracking
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready && q.size() > 0)
        void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e     = model(bus.man_x, bus.man_y);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() == 0) begin
        chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
      end else begin
        chk("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
        if (!q[0].seen) begin
          if (bus.out_valid) begin
            chk("latency", cyc - q[0].acc, q[0].lat);
            q[0].seen = 1'b1;
          end else if (cyc - q[0].acc > q[0].lat) begin
            chk("late_out_valid", cyc - q[0].acc, q[0].lat);
            q[0].seen = 1'b1;
          end
        end
        if (q[0].seen)
          chk("out_fields",
              {4'd0, bus.result, bus.guard, bus.sticky,
               bus.redundant_div, bus.div_by_zero},
              pack(q[0]));
      end
    end
  end

  always @(negedge clk)
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic issue(logic [23:0] x, logic [23:0] y);
    int i;
    @(negedge clk);
    bus.man_x    = x;
    bus.man_y    = y;
    bus.in_valid = 1'b1;
    for (i = 0; i < 400 && !bus.in_ready; i++) @(negedge clk);
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.man_x    = 24'($urandom);
    bus.man_y    = 24'($urandom);
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
    if (!bus.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 600 && (q.size() != 0 || !bus.in_ready); i++)
      @(negedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [23:0] x, y;

    bus.in_valid  = 1'b0;
    bus.man_x     = '0;
    bus.man_y     = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_fields",
        {4'd0, bus.result, bus.guard, bus.sticky,
         bus.redundant_div, bus.div_by_zero}, 32'd0);
    rst = 1'b0;

    e = model(24'h800000, 24'h800000);
    chk("model_1_over_1", pack(e), {4'd0, 24'h800000, 4'b0000});
    e = model(24'h800000, 24'hC00000);
    chk("model_2_over_3", pack(e), {4'd0, 24'hAAAAAA, 4'b1110});
    e = model(24'hFFFFFF, 24'h800000);
    chk("model_max_over_1", pack(e), {4'd0, 24'hFFFFFF, 4'b0000});
    e = model(24'hABCDEF, 24'h000000);
    chk("model_div0", pack(e), {4'd0, 24'hFFFFFF, 4'b0001});
    chk("model_div0_lat", e.lat, 32'd0);
    e = model(24'h000000, 24'h9ABCDE);
    chk("model_zero_x", pack(e), {4'd0, 24'h000000, 4'b0010});

    bus.out_ready = 1'b1;
    issue(24'h800000, 24'h800000);
    issue(24'h800000, 24'hC00000);
    issue(24'hFFFFFF, 24'h800000);
    issue(24'hABCDEF, 24'h000000);
    issue(24'h000000, 24'h9ABCDE);
    issue(24'h123456, 24'hFFFFFF);
    drain();

    // backpressure hold
    bus.out_ready = 1'b0;
    issue(24'h800000, 24'hC00000);
    wait_valid();
    repeat (10) begin
      @(negedge clk);
      chk("bp_result", {8'd0, bus.result}, 32'hAAAAAA);
      chk("bp_flags",
          {28'd0, bus.guard, bus.sticky,
           bus.redundant_div, bus.div_by_zero}, 32'b1110);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    drain();

    // reset mid-CALC with in_valid held high
    @(negedge clk);
    bus.man_x    = 24'hFFFFFF;
    bus.man_y    = 24'h800000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid();
    chk("abort_next_result", {8'd0, bus.result}, 32'hFFFFFF);
    drain();

    // randomized traffic with random backpressure
    rand_ready = 1'b1;
    repeat (40) begin
      case ($urandom_range(0, 9))
        0:       y = 24'd0;
        default: y = {1'b1, 23'($urandom)};
      endcase
      case ($urandom_range(0, 9))
        0:       x = 24'd0;
        1, 2:    x = {1'b0, 23'($urandom)};
        default: x = {1'b1, 23'($urandom)};
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(x, y);
    end
    drain();
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
